// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port 32-bit word store behind a level-handshake request
// interface. Every legal access is BUSY for LAT+1 cycles, then ACCESS for
// one cycle. Illegal requests report ERROR at once and set a sticky flag.
//
// state | meaning
// IDLE  | no access in flight; the current inputs are evaluated directly
// WAIT  | legal request latched, counting down the extra wait cycles
// DONE  | latency elapsed; ACCESS is driven if the request is unchanged
module ram_ctrl #(
    parameter int LAT    = 2,
    parameter int ADDR_W = 14
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        ramREN,
    input  logic        ramWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        err_flag
);

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_q, op_d;          // 1 = write
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                start_eval;

    logic [31:0]         mem [2**ADDR_W];

    logic                req;
    logic                illegal;
    logic                cur_wr;
    logic [ADDR_W-1:0]   cur_idx;
    logic                match;

    assign req     = ramREN | ramWEN;
    assign illegal = (ramREN & ramWEN)
                   | (ramaddr[1:0] != 2'b00)
                   | (ramaddr[31:ADDR_W+2] != '0);
    assign cur_wr  = ramWEN;
    assign cur_idx = ramaddr[ADDR_W+1:2];

    // A latched access only proceeds while the arbiter keeps presenting
    // exactly the same legal request; any difference restarts it.
    assign match = req & ~illegal
                 & (cur_wr == op_q)
                 & (cur_idx == idx_q)
                 & (ramstore == data_q);

    // Next-state, latch updates, counters and ramstate decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        start_eval = 1'b0;
        ramstate   = RS_FREE;

        case (state_q)
            ST_IDLE: begin
                start_eval = 1'b1;
            end
            ST_WAIT: begin
                if (match) begin
                    ramstate = RS_BUSY;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_DONE;
                        cnt_d   = 4'd0;
                        rdata_d = mem[idx_q];
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    start_eval = 1'b1;
                end
            end
            ST_DONE: begin
                if (match) begin
                    ramstate = RS_ACCESS;
                    state_d  = ST_IDLE;
                    if (op_q) begin
                        mem_we = 1'b1;
                        if (wr_count_q != 16'hFFFF) begin
                            wr_count_d = wr_count_q + 16'd1;
                        end
                    end else if (rd_count_q != 16'hFFFF) begin
                        rd_count_d = rd_count_q + 16'd1;
                    end
                end else begin
                    start_eval = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Fresh evaluation of the inputs, shared by IDLE and by any
        // dropped or changed request in WAIT/DONE.
        if (start_eval) begin
            state_d = ST_IDLE;
            if (!req) begin
                ramstate = RS_FREE;
            end else if (illegal) begin
                ramstate = RS_ERROR;
                err_d    = 1'b1;
            end else begin
                ramstate = RS_BUSY;
                op_d     = cur_wr;
                idx_d    = cur_idx;
                data_d   = ramstore;
                cnt_d    = 4'(LAT);
                if (LAT > 0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                    rdata_d = mem[cur_idx];
                end
            end
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 1'b0;
            idx_q      <= '0;
            data_q     <= 32'd0;
            rdata_q    <= 32'd0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
        end
    end

    // Storage array: written at the edge ending a write ACCESS, never reset.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[idx_q] <= data_q;
        end
    end

    assign ramload  = (state_q == ST_DONE && match && !op_q) ? rdata_q : 32'd0;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign err_flag = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: two instances (LAT=2 at index 0, LAT=0 at index 1),
// directed scenarios followed by random accesses checked against a
// transaction-level model (word map, latency LAT+1, saturating counts).
module tb_ram_ctrl;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr  [2];
    logic [31:0] store [2];
    logic        ren   [2];
    logic        wen   [2];
    logic [31:0] load  [2];
    logic [1:0]  rstate[2];
    logic [15:0] rdc   [2];
    logic [15:0] wrc   [2];
    logic        errf  [2];

    int          checks = 0;
    int          errors = 0;
    int          exp_rd [2];
    int          exp_wr [2];
    logic        exp_err[2];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    ram_ctrl #(.LAT(2), .ADDR_W(14)) u_lat2 (
        .CLK(clk), .RST(rst), .ramaddr(addr[0]), .ramstore(store[0]),
        .ramREN(ren[0]), .ramWEN(wen[0]), .ramload(load[0]), .ramstate(rstate[0]),
        .rd_count(rdc[0]), .wr_count(wrc[0]), .err_flag(errf[0])
    );

    ram_ctrl #(.LAT(0), .ADDR_W(14)) u_lat0 (
        .CLK(clk), .RST(rst), .ramaddr(addr[1]), .ramstore(store[1]),
        .ramREN(ren[1]), .ramWEN(wen[1]), .ramload(load[1]), .ramstate(rstate[1]),
        .rd_count(rdc[1]), .wr_count(wrc[1]), .err_flag(errf[1])
    );

    function automatic int lat(int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    function automatic int key(int sel, logic [31:0] a);
        return sel * 65536 + int'(a[15:2]);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(int sel, string tag);
        chk($sformatf("%s_rd_count_s%0d", tag, sel), 32'(rdc[sel]), 32'(exp_rd[sel]));
        chk($sformatf("%s_wr_count_s%0d", tag, sel), 32'(wrc[sel]), 32'(exp_wr[sel]));
        chk($sformatf("%s_err_flag_s%0d", tag, sel), 32'(errf[sel]), 32'(exp_err[sel]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(int sel);
        ren[sel] = 1'b0;
        wen[sel] = 1'b0;
    endtask

    // Legal access from cycle 0; hold=1 leaves the request asserted so the
    // caller can chain a back-to-back access in the next cycle.
    task automatic access(int sel, bit wr, logic [31:0] a, logic [31:0] d, bit hold);
        int l;
        l = lat(sel);
        addr[sel]  = a;
        store[sel] = d;
        ren[sel]   = !wr;
        wen[sel]   = wr;
        for (int k = 0; k <= l; k++) begin
            @(negedge clk);
            chk($sformatf("busy_s%0d_c%0d_a%h", sel, k, a), 32'(rstate[sel]), 32'(BUSY));
            chk($sformatf("busy_load_s%0d_c%0d", sel, k), load[sel], 32'd0);
            if (k == 0) chk_status(sel, "pre");
            tick();
        end
        @(negedge clk);
        chk($sformatf("access_s%0d_a%h", sel, a), 32'(rstate[sel]), 32'(ACCESS));
        if (wr) chk($sformatf("wr_load_s%0d", sel), load[sel], 32'd0);
        else    chk($sformatf("rd_data_s%0d_a%h", sel, a), load[sel], mdl[key(sel, a)]);
        @(posedge clk);
        if (wr) begin
            mdl[key(sel, a)] = d;
            if (exp_wr[sel] < 65535) exp_wr[sel]++;
        end else begin
            if (exp_rd[sel] < 65535) exp_rd[sel]++;
        end
        #1;
        if (!hold) begin
            drop(sel);
            @(negedge clk);
            chk($sformatf("free_after_s%0d", sel), 32'(rstate[sel]), 32'(FREE));
            chk_status(sel, "post");
            tick();
        end
    endtask

    task automatic illegal(int sel, logic r, logic w, logic [31:0] a, logic [31:0] d);
        addr[sel]  = a;
        store[sel] = d;
        ren[sel]   = r;
        wen[sel]   = w;
        @(negedge clk);
        chk($sformatf("err_state_s%0d_a%h", sel, a), 32'(rstate[sel]), 32'(ERROR));
        chk($sformatf("err_load_s%0d", sel), load[sel], 32'd0);
        chk($sformatf("err_flag_before_s%0d", sel), 32'(errf[sel]), 32'(exp_err[sel]));
        @(posedge clk);
        exp_err[sel] = 1'b1;
        #1;
        drop(sel);
        @(negedge clk);
        chk($sformatf("err_free_s%0d", sel), 32'(rstate[sel]), 32'(FREE));
        chk_status(sel, "err");
        tick();
    endtask

    // Request withdrawn in cycle 'when' (1..LAT+1): no write, no count.
    task automatic abort(int sel, bit wr, logic [31:0] a, logic [31:0] d, int when);
        addr[sel]  = a;
        store[sel] = d;
        ren[sel]   = !wr;
        wen[sel]   = wr;
        for (int k = 0; k < when; k++) begin
            @(negedge clk);
            chk($sformatf("abort_busy_s%0d_c%0d", sel, k), 32'(rstate[sel]), 32'(BUSY));
            tick();
        end
        drop(sel);
        @(negedge clk);
        chk($sformatf("abort_free_s%0d_c%0d", sel, when), 32'(rstate[sel]), 32'(FREE));
        chk($sformatf("abort_load_s%0d", sel), load[sel], 32'd0);
        chk_status(sel, "abort");
        tick();
    endtask

    // Request changed in cycle 'when': from then on it behaves as a new
    // access whose cycle 0 is the cycle of the change.
    task automatic restart(int sel, bit wr, logic [31:0] a1, logic [31:0] d1,
                           logic [31:0] a2, logic [31:0] d2, int when);
        addr[sel]  = a1;
        store[sel] = d1;
        ren[sel]   = !wr;
        wen[sel]   = wr;
        for (int k = 0; k < when; k++) begin
            @(negedge clk);
            chk($sformatf("restart_busy_s%0d_c%0d", sel, k), 32'(rstate[sel]), 32'(BUSY));
            tick();
        end
        access(sel, wr, a2, d2, 1'b0);
    endtask

    logic [31:0] ra, ra2, rd, rd2;
    int          rsel, rkind, rwhen, rv;
    bit          rwr;

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            addr[s] = 32'd0; store[s] = 32'd0; ren[s] = 1'b0; wen[s] = 1'b0;
            exp_rd[s] = 0; exp_wr[s] = 0; exp_err[s] = 1'b0;
        end
        tick();
        tick();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_state_s%0d", s), 32'(rstate[s]), 32'(FREE));
            chk($sformatf("reset_load_s%0d", s), load[s], 32'd0);
            chk_status(s, "reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LAT=2 write then read of 0x100, first request in the first low cycle
        access(0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 32'h100, 32'h0, 1'b0);

        // LAT=0: back-to-back two-word write, then back-to-back reads
        access(1, 1'b1, 32'h200, 32'h11, 1'b1);
        access(1, 1'b1, 32'h204, 32'h22, 1'b0);
        access(1, 1'b0, 32'h200, 32'h0, 1'b1);
        access(1, 1'b0, 32'h204, 32'h0, 1'b0);

        // address change during WAIT restarts the countdown; 0x40 untouched
        access(0, 1'b1, 32'h40, 32'hA5A50040, 1'b0);
        restart(0, 1'b1, 32'h40, 32'h1234, 32'h44, 32'h1234, 1);
        access(0, 1'b0, 32'h40, 32'h0, 1'b0);
        access(0, 1'b0, 32'h44, 32'h0, 1'b0);

        // illegal requests: both enables, misaligned, out of range
        access(0, 1'b1, 32'h0, 32'h0000CAFE, 1'b0);
        illegal(0, 1'b1, 1'b1, 32'h100, 32'hBAD00001);
        illegal(0, 1'b0, 1'b1, 32'h102, 32'hBAD00002);
        illegal(0, 1'b0, 1'b1, 32'h0001_0000, 32'hBAD00003);
        access(0, 1'b0, 32'h100, 32'h0, 1'b0);
        access(0, 1'b0, 32'h0, 32'h0, 1'b0);

        // reset during WAIT of a write to 0x300 aborts it
        access(0, 1'b1, 32'h300, 32'h03000300, 1'b0);
        addr[0] = 32'h300; store[0] = 32'hFFFF0000; wen[0] = 1'b1; ren[0] = 1'b0;
        @(negedge clk);
        chk("rst_abort_busy_c0", 32'(rstate[0]), 32'(BUSY));
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_busy_c1", 32'(rstate[0]), 32'(BUSY));
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            exp_rd[s] = 0; exp_wr[s] = 0; exp_err[s] = 1'b0;
        end
        #1;
        rst = 1'b0;
        drop(0);
        @(negedge clk);
        chk("rst_abort_free", 32'(rstate[0]), 32'(FREE));
        chk_status(0, "rst_abort");
        chk_status(1, "rst_abort");
        tick();
        access(0, 1'b0, 32'h300, 32'h0, 1'b0);

        // random phase over a 16-word pool, seeded in both instances
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                access(s, 1'b1, 32'h1000 + 32'(i * 4), $urandom(), 1'b0);
        for (int it = 0; it < 120; it++) begin
            rsel  = $urandom_range(0, 1);
            rkind = $urandom_range(0, 9);
            ra    = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            ra2   = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            rd    = $urandom();
            rd2   = $urandom();
            rwr   = 1'($urandom_range(0, 1));
            if (rkind <= 4) begin
                access(rsel, rwr, ra, rd, 1'b0);
            end else if (rkind <= 6) begin
                rv = $urandom_range(0, 2);
                if (rv == 0)      illegal(rsel, 1'b1, 1'b1, ra, rd);
                else if (rv == 1) illegal(rsel, 1'b0, 1'b1, ra | 32'($urandom_range(1, 3)), rd);
                else              illegal(rsel, !rwr, rwr, ra | (32'h1 << $urandom_range(16, 31)), rd);
            end else if (rkind == 7) begin
                rwhen = $urandom_range(1, lat(rsel) + 1);
                abort(rsel, rwr, ra, rd, rwhen);
            end else begin
                rwhen = $urandom_range(1, lat(rsel) + 1);
                if (ra2 == ra && rd2 == rd) rd2 = ~rd;
                restart(rsel, rwr, ra, rd, ra2, rd2, rwhen);
            end
        end
        for (int i = 0; i < 16; i++) begin
            access(0, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 1'b0);
            access(1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 1'b0);
        end

        // read counter saturation: preload near the ceiling, then keep reading
        u_lat0.rd_count_q = 16'hFFF8;
        exp_rd[1] = 32'hFFF8;
        for (int n = 0; n < 10; n++)
            access(1, 1'b0, 32'h200, 32'h0, n < 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
